// File: rtl/alu_pipe_pkg.sv
// Shared types for alu_pipe: 4-bit opcode encoding and accumulator group state.
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        OpAdd   = 4'd0,
        OpSub   = 4'd1,
        OpPass0 = 4'd2,
        OpPass1 = 4'd3,
        OpAnd   = 4'd4,
        OpOr    = 4'd5,
        OpXor   = 4'd6,
        OpShl   = 4'd7,
        OpShr   = 4'd8,
        OpSlt   = 4'd9,
        OpAcc   = 4'd10,
        OpMul   = 4'd11
    } op_e;

    typedef enum logic [0:0] {
        AccIdle,
        AccAccum
    } acc_state_e;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational opcode decode/compute for alu_pipe.
// Opcode 11 computes a multiply only when ALU_PIPE_MUL_EN is defined; otherwise it yields 0.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned ShW = $clog2(WIDTH);

    logic [ShW-1:0] shamt;
    logic           lt_signed;

    assign shamt     = b[ShW-1:0];
    assign lt_signed = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        case (op)
            OpAdd:   result = a + b;
            OpSub:   result = a - b;
            OpPass0: result = a;
            OpPass1: result = b;
            OpAnd:   result = a & b;
            OpOr:    result = a | b;
            OpXor:   result = a ^ b;
            OpShl:   result = a << shamt;
            OpShr:   result = a >> shamt;
            OpSlt:   result = {{(WIDTH-1){1'b0}}, lt_signed};
            // Only the final beat of a group reaches this stage, carrying the full sum in a.
            OpAcc:   result = a;
`ifdef ALU_PIPE_MUL_EN
            OpMul:   result = a * b;
`endif
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with valid/ready handshake and grouped accumulate (ACC) support.
// Build option: ALU_PIPE_MUL_EN enables the multiplier behind opcode 11.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       config_sig,
    input  logic [CNT_W-1:0] acc_len,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             en;
    logic             accept;
    logic             is_acc;
    logic             acc_last;
    logic             acc_emit;
    logic             s1_load;
    logic [WIDTH-1:0] s1_a_d;

    acc_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_inc;

    logic             s1_valid_q;
    logic [3:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [WIDTH-1:0] core_result;
    logic             out_valid_q;
    logic [WIDTH-1:0] out0_q;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign accept    = in_valid && en;
    assign is_acc    = (config_sig == OpAcc);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign acc_last  = (cnt_inc == len_q);
    assign out0      = out0_q;
    assign out_valid = out_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= AccIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (accept) begin
            if (is_acc) begin
                if (state_q == AccIdle) begin
                    // A single-beat group bypasses ACCUM and is emitted directly.
                    if (acc_len != '0) begin
                        state_d = AccAccum;
                        acc_d   = in0;
                        cnt_d   = '0;
                        len_d   = acc_len;
                    end
                end else if (acc_last) begin
                    state_d = AccIdle;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    acc_d = acc_q + in0;
                    cnt_d = cnt_inc;
                end
            end else if (state_q == AccAccum) begin
                // Non-ACC beat aborts the group; the partial sum is dropped.
                state_d = AccIdle;
                acc_d   = '0;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        acc_emit = 1'b0;
        s1_a_d   = in0;
        if (is_acc) begin
            if (state_q == AccIdle) begin
                acc_emit = (acc_len == '0);
            end else begin
                acc_emit = acc_last;
                s1_a_d   = acc_q + in0;
            end
        end
        s1_load = accept && (!is_acc || acc_emit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            out_valid_q <= 1'b0;
            out0_q      <= '0;
        end else if (en) begin
            s1_valid_q <= s1_load;
            if (s1_load) begin
                s1_op_q <= config_sig;
                s1_a_q  <= s1_a_d;
                s1_b_q  <= in1;
            end
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out0_q <= core_result;
            end
        end
    end

    alu_pipe_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (s1_op_q),
        .a      (s1_a_q),
        .b      (s1_b_q),
        .result (core_result)
    );

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: table-driven single-op vectors plus directed
// sequences for back-to-back issue, accumulate groups, stalls and reset.
module tb_alu_pipe;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_P0  = 4'd2;
    localparam logic [3:0] OP_P1  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_SLT = 4'd9;
    localparam logic [3:0] OP_ACC = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

`ifdef ALU_PIPE_MUL_EN
    localparam logic [31:0] MUL_6X7 = 32'd42;
`else
    localparam logic [31:0] MUL_6X7 = 32'd0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 18;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  config_sig;
    logic [3:0]  acc_len;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out0;
    logic        out_valid;
    logic        out_ready;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] res_val[$];
    int          res_cyc[$];
    vec_t        vecs[NVEC];

    alu_pipe #(
        .WIDTH (32),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .config_sig (config_sig),
        .acc_len    (acc_len),
        .in0        (in0),
        .in1        (in1),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0       (out0),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed output transfer with the cycle it was visible in.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            res_val.push_back(out0);
            res_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_results();
        res_val.delete();
        res_cyc.delete();
    endtask

    // Offer one beat and hold it until accepted (bounded).
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] len);
        logic took;
        int   n;
        config_sig = op;
        in0        = a;
        in1        = b;
        acc_len    = len;
        in_valid   = 1'b1;
        n          = 0;
        took       = 1'b0;
        do begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!took && n < 50);
        in_valid = 1'b0;
        if (!took) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance");
        end
    endtask

    task automatic wait_results(input int k);
        int n;
        n = 0;
        while (res_val.size() < k && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int          t0;
        int          sent;
        logic [31:0] nv;
        logic        took;

        vecs[0]  = '{OP_ADD, 32'd5,          32'd3,          32'd8};
        vecs[1]  = '{OP_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF};
        vecs[2]  = '{OP_P0,  32'hDEAD_BEEF,  32'h1234_5678,  32'hDEAD_BEEF};
        vecs[3]  = '{OP_P1,  32'hDEAD_BEEF,  32'h1234_5678,  32'h1234_5678};
        vecs[4]  = '{OP_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000};
        vecs[5]  = '{OP_OR,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0};
        vecs[6]  = '{OP_XOR, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0};
        vecs[7]  = '{OP_SHL, 32'd1,          32'd33,         32'd2};
        vecs[8]  = '{OP_SHR, 32'h8000_0000,  32'd31,         32'd1};
        vecs[9]  = '{OP_SHR, 32'h8000_0000,  32'h0000_0104,  32'h0800_0000};
        vecs[10] = '{OP_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[11] = '{OP_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[12] = '{OP_ADD, 32'hFFFF_FFFF,  32'd2,          32'd1};
        vecs[13] = '{4'd12,  32'd7,          32'd9,          32'd0};
        vecs[14] = '{4'd15,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0};
        vecs[15] = '{OP_MUL, 32'h0001_0000,  32'h0001_0000,  32'd0};
        vecs[16] = '{OP_MUL, 32'd6,          32'd7,          MUL_6X7};
        vecs[17] = '{OP_SUB, 32'd3,          32'd5,          32'hFFFF_FFFE};

        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        config_sig = '0;
        acc_len    = '0;
        in0        = '0;
        in1        = '0;

        // Reset state
        idle(3);
        @(negedge clk);
        check("rst_in_ready_during", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out0", out0, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready_after", 32'(in_ready), 32'd1);
        idle(3);
        check("rst_no_output", 32'(res_val.size()), 32'd0);

        // Single-op vectors with latency check
        for (int i = 0; i < NVEC; i++) begin
            clear_results();
            t0 = cyc;
            send(vecs[i].op, vecs[i].a, vecs[i].b, 4'd0);
            wait_results(1);
            idle(3);
            check($sformatf("vec%0d_op%0d_count", i, vecs[i].op), 32'(res_val.size()), 32'd1);
            if (res_val.size() >= 1) begin
                check($sformatf("vec%0d_op%0d_value", i, vecs[i].op), res_val[0], vecs[i].exp);
                check($sformatf("vec%0d_latency", i), 32'(res_cyc[0] - t0), 32'd2);
            end
        end

        // Back-to-back ops, one result per cycle
        clear_results();
        t0 = cyc;
        send(OP_ADD, 32'd5, 32'd3, 4'd0);
        send(OP_SUB, 32'd5, 32'd3, 4'd0);
        send(OP_P0,  32'd5, 32'd3, 4'd0);
        send(OP_P1,  32'd5, 32'd3, 4'd0);
        wait_results(4);
        idle(3);
        check("b2b_count", 32'(res_val.size()), 32'd4);
        if (res_val.size() == 4) begin
            check("b2b_val0", res_val[0], 32'd8);
            check("b2b_val1", res_val[1], 32'd2);
            check("b2b_val2", res_val[2], 32'd5);
            check("b2b_val3", res_val[3], 32'd3);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("b2b_cycle%0d", i), 32'(res_cyc[i] - t0), 32'(i + 2));
            end
        end

        // ACC group of four with bubbles
        clear_results();
        send(OP_ACC, 32'd10, 32'd0, 4'd3);
        idle(1);
        send(OP_ACC, 32'd20, 32'd0, 4'd3);
        idle(2);
        send(OP_ACC, 32'd30, 32'd0, 4'd3);
        idle(1);
        t0 = cyc;
        send(OP_ACC, 32'd40, 32'd0, 4'd3);
        wait_results(1);
        idle(4);
        check("acc4_count", 32'(res_val.size()), 32'd1);
        if (res_val.size() >= 1) begin
            check("acc4_value", res_val[0], 32'd100);
            check("acc4_latency", 32'(res_cyc[0] - t0), 32'd2);
        end

        // ACC aborted by ADD, then a single-beat group, then a fresh two-beat group
        clear_results();
        send(OP_ACC, 32'd7, 32'd0, 4'd3);
        send(OP_ACC, 32'd8, 32'd0, 4'd3);
        send(OP_ADD, 32'd1, 32'd1, 4'd3);
        send(OP_ACC, 32'd9, 32'd0, 4'd0);
        send(OP_ACC, 32'd5, 32'd0, 4'd1);
        send(OP_ACC, 32'd6, 32'd0, 4'd1);
        wait_results(3);
        idle(4);
        check("abort_count", 32'(res_val.size()), 32'd3);
        if (res_val.size() == 3) begin
            check("abort_add", res_val[0], 32'd2);
            check("abort_acc_len0", res_val[1], 32'd9);
            check("abort_acc_fresh", res_val[2], 32'd11);
        end

        // Output stall with a continuous ADD stream
        clear_results();
        config_sig = OP_ADD;
        acc_len    = 4'd0;
        in1        = 32'd100;
        nv         = 32'd1;
        in0        = nv;
        in_valid   = 1'b1;
        sent       = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = (c >= 7);
            @(negedge clk);
            took = in_valid && in_ready;
            if (c >= 2 && c <= 6) begin
                check($sformatf("stall_in_ready_c%0d", c), 32'(in_ready), 32'd0);
                check($sformatf("stall_out_valid_c%0d", c), 32'(out_valid), 32'd1);
                check($sformatf("stall_out0_c%0d", c), out0, 32'd101);
            end
            @(posedge clk);
            #1;
            if (took) begin
                sent++;
                nv = nv + 32'd1;
                in0 = nv;
                if (sent == 6) in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_results(6);
        idle(3);
        check("stall_count", 32'(res_val.size()), 32'd6);
        if (res_val.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("stall_val%0d", i), res_val[i], 32'(101 + i));
            end
        end

        // Reset mid-group with a stalled pipeline discards everything
        clear_results();
        out_ready = 1'b1;
        send(OP_ACC, 32'd10, 32'd0, 4'd3);
        send(OP_ACC, 32'd20, 32'd0, 4'd3);
        out_ready = 1'b0;
        send(OP_ADD, 32'd1, 32'd1, 4'd0);
        send(OP_ADD, 32'd2, 32'd2, 4'd0);
        reset = 1'b1;
        idle(2);
        reset     = 1'b0;
        out_ready = 1'b1;
        idle(6);
        check("rst_mid_no_output", 32'(res_val.size()), 32'd0);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        send(OP_ACC, 32'd3, 32'd0, 4'd1);
        send(OP_ACC, 32'd4, 32'd0, 4'd1);
        wait_results(1);
        idle(4);
        check("rst_mid_acc_count", 32'(res_val.size()), 32'd1);
        if (res_val.size() >= 1) begin
            check("rst_mid_acc_value", res_val[0], 32'd7);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits (>=8, power of two).
REQ-002 Parameter CNT_W, default 4, width of accumulate-length field.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port config_sig  input  4  opcode, sampled with each accepted input beat.
REQ-006 Port acc_len  input  CNT_W  accumulate group size minus one, sampled on first beat of a group.
REQ-007 Port in0  input  WIDTH  operand A.
REQ-008 Port in1  input  WIDTH  operand B.
REQ-009 Port in_valid  input  1  operand beat offered.
REQ-010 Port in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-011 Port out0  output  WIDTH  registered result.
REQ-012 Port out_valid  output  1  out0 holds a result.
REQ-013 Port out_ready  input  1  consumer takes result when out_valid && out_ready.

Function
REQ-014 Opcodes SHALL be: 0 ADD, 1 SUB (in0-in1), 2 PASS0, 3 PASS1, 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR logical, 9 SLT signed (1/0), 10 ACC, 11 MUL; 12-15 yield 0 with out_valid asserted.
REQ-015 Shift amount SHALL be in1[log2(WIDTH)-1:0]; upper in1 bits ignored.
REQ-016 All arithmetic SHALL wrap modulo 2^WIDTH; no saturation, no flags.
REQ-017 Pipeline SHALL be two stages: S1 registers operands/opcode, S2 registers result into out0.
REQ-018 Latency SHALL be exactly 2 cycles from accepted beat to out_valid when out_ready stays high; throughput one beat per cycle.
REQ-019 Global enable en = !out_valid || out_ready; in_ready SHALL equal en; when en=0 both stages SHALL hold contents.
REQ-020 out0 and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-021 ACC: state IDLE/ACCUM; first ACC beat loads acc=in0, latches acc_len, count=0, enters ACCUM (or emits immediately if acc_len=0).
REQ-022 ACC in ACCUM: each beat acc+=in0, count+=1; beat with count==latched len emits acc+in0 as one result, returns to IDLE; non-final ACC beats produce no output.
REQ-023 A non-ACC beat arriving in ACCUM SHALL abort the group (acc, count cleared, IDLE, partial sum discarded) and be processed normally.
REQ-024 Bubbles (in_valid=0) SHALL NOT advance count or alter acc.

Reset
REQ-025 On reset: out0=0, out_valid=0, S1 valid=0, acc=0, count=0, state IDLE; in_ready=1 during and after reset.
REQ-026 Reset mid-group or with stalled output SHALL discard all in-flight data; no result emitted afterwards.

Configuration
REQ-027 Macro ALU_PIPE_MUL_EN defined: opcode 11 yields low WIDTH bits of in0*in1, same 2-cycle latency.
REQ-028 ALU_PIPE_MUL_EN undefined: no multiplier synthesised; opcode 11 behaves as 12-15 (result 0, out_valid asserted).

Structure
REQ-029 Package alu_pipe_pkg SHALL hold opcode enum (4-bit) and ACC state enum.
REQ-030 Sub-module alu_pipe_core SHALL hold the combinational opcode decode/compute; alu_pipe holds pipeline, handshake, accumulator.

Verification
REQ-031 Reset, then in0=5,in1=3, ops 0,1,2,3 back-to-back, out_ready=1 -> 8,2,5,3 on consecutive cycles, first 2 cycles after first beat.
REQ-032 SUB 0-1 -> 0xFFFFFFFF; SLT in0=0xFFFFFFFF,in1=1 -> 1; SHL in0=1,in1=33 -> 2.
REQ-033 ACC acc_len=3, in0=10,20,30,40 with bubbles between -> single result 100, no other out_valid pulses.
REQ-034 ACC acc_len=3, two beats 7,8 then ADD 1+1 -> only result 2; following ACC group acc_len=0 in0=9 -> 9.
REQ-035 out_ready=0 for 5 cycles with stream of ADD beats -> in_ready low after pipeline fills, out0 stable, no loss/duplication on release.
REQ-036 MUL 0x10000*0x10000 -> 0 with ALU_PIPE_MUL_EN, 0 without; 6*7 -> 42 with, 0 without.
